// File: rtl/timer_pkg.sv
// Shared types, constants and helpers for the egg-timer countdown datapath.
package timer_pkg;

    // One packed BCD digit.
    typedef logic [3:0] bcd_digit_t;

    // Largest legal value of a BCD digit.
    localparam bcd_digit_t BCD_MAX = 4'd9;

    // Default number of packed BCD digits in the countdown register (00-99).
    localparam int DEFAULT_NUM_DIGITS = 2;

    // Clamp a nibble into the legal BCD range so the register never holds A-F.
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nibble);
        bcd_digit_t result;
        if (nibble > BCD_MAX) begin
            result = BCD_MAX;
        end else begin
            result = nibble;
        end
        return result;
    endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// Single BCD digit decrementer; chained to form a multi-digit borrow ripple.
module bcd_digit_dec
    import timer_pkg::*;
(
    input  logic [3:0] digit_in,
    input  logic       borrow_in,
    output logic [3:0] digit_out,
    output logic       borrow_out
);

    // Subtract the incoming borrow; a zero digit wraps to 9 and borrows upward.
    always_comb begin
        digit_out  = digit_in;
        borrow_out = 1'b0;
        if (borrow_in) begin
            if (digit_in == 4'd0) begin
                digit_out  = BCD_MAX;
                borrow_out = 1'b1;
            end else begin
                digit_out  = digit_in - 4'd1;
                borrow_out = 1'b0;
            end
        end else begin
            digit_out  = digit_in;
            borrow_out = 1'b0;
        end
    end

endmodule

// File: rtl/decrement_time.sv
// Countdown register for the egg timer: packed BCD, loadable, saturating at zero.
module decrement_time
    import timer_pkg::*;
#(
    parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    writeEnable,
    input  logic                    decrementEnable,
    input  logic [4*NUM_DIGITS-1:0] inputTime,
    output logic [4*NUM_DIGITS-1:0] outputTime,
    output logic                    isZero
);

    localparam int DW = 4 * NUM_DIGITS;

    logic [DW-1:0]       count_q;
    logic [DW-1:0]       count_d;
    logic [DW-1:0]       load_val_s;
    logic [DW-1:0]       dec_val_s;
    logic [NUM_DIGITS:0] borrow_s;
    logic                is_zero_s;
    logic                dec_req_s;

    // The count is all zeros exactly when every bit is clear.
    assign is_zero_s = ~|count_q;

    // Decrementing from zero is suppressed here so the chain never sees an underflow request.
    assign dec_req_s = decrementEnable & ~is_zero_s;

    assign borrow_s[0] = dec_req_s;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            bcd_digit_dec u_dec (
                .digit_in   (count_q[gi*4 +: 4]),
                .borrow_in  (borrow_s[gi]),
                .digit_out  (dec_val_s[gi*4 +: 4]),
                .borrow_out (borrow_s[gi+1])
            );
        end
    endgenerate

    // Sanitise the load value digit by digit so only valid BCD is ever stored.
    always_comb begin
        load_val_s = {DW{1'b0}};
        for (int i = 0; i < NUM_DIGITS; i++) begin
            load_val_s[i*4 +: 4] = bcd_clamp(inputTime[i*4 +: 4]);
        end
    end

    // Next count: load wins over decrement; a borrow out of the top digit would mean underflow, so hold instead.
    always_comb begin
        count_d = count_q;
        if (writeEnable) begin
            count_d = load_val_s;
        end else if (dec_req_s && !borrow_s[NUM_DIGITS]) begin
            count_d = dec_val_s;
        end else begin
            count_d = count_q;
        end
    end

    // Count register; reset clears it immediately, independent of the clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= {DW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign outputTime = count_q;
    assign isZero     = is_zero_s;

endmodule

// File: tb/tb_decrement_time.sv
// Scoreboard bench for decrement_time: stimulus pushes expected values, a monitor pops and compares.
module tb_decrement_time;

    logic       clk;
    logic       reset;
    logic       writeEnable;
    logic       decrementEnable;
    logic [7:0] inputTime;
    logic [7:0] outputTime;
    logic       isZero;

    int checks   = 0;
    int failures = 0;

    // Expected {isZero, outputTime} after each sampled edge.
    logic [8:0] exp_q[$];
    logic [8:0] exp_e;

    decrement_time #(.NUM_DIGITS(2)) dut (
        .clk             (clk),
        .reset           (reset),
        .writeEnable     (writeEnable),
        .decrementEnable (decrementEnable),
        .inputTime       (inputTime),
        .outputTime      (outputTime),
        .isZero          (isZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: one cycle after each edge, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            checks++;
            if (outputTime !== exp_e[7:0] || isZero !== exp_e[8]) begin
                failures++;
                $display("FAIL seq_check: got time=%h zero=%b, expected time=%h zero=%b",
                         outputTime, isZero, exp_e[7:0], exp_e[8]);
            end
        end
    end

    task automatic direct_check(input string name, input logic [7:0] t, input logic z);
        checks++;
        if (outputTime !== t || isZero !== z) begin
            failures++;
            $display("FAIL %s: got time=%h zero=%b, expected time=%h zero=%b",
                     name, outputTime, isZero, t, z);
        end
    endtask

    // Drive one cycle of enables at the falling edge and record what the next rising edge must produce.
    task automatic step(input logic we, input logic de, input logic [7:0] din, input logic [7:0] exp_t);
        @(negedge clk);
        writeEnable     = we;
        decrementEnable = de;
        inputTime       = din;
        exp_q.push_back({(exp_t == 8'h00), exp_t});
        @(posedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        writeEnable     = 1'b0;
        decrementEnable = 1'b0;
        inputTime       = 8'h00;
        #10;
        direct_check("reset_hold", 8'h00, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        direct_check("reset_release", 8'h00, 1'b1);

        // Idle after reset; inputTime must be ignored without writeEnable.
        step(1'b0, 1'b0, 8'h55, 8'h00);

        // Load then count down across the 20->19 borrow.
        step(1'b1, 1'b0, 8'h22, 8'h22);
        step(1'b0, 1'b1, 8'h77, 8'h21);
        step(1'b0, 1'b1, 8'h33, 8'h20);
        step(1'b0, 1'b1, 8'h44, 8'h19);
        step(1'b0, 1'b1, 8'h00, 8'h18);
        step(1'b0, 1'b1, 8'h99, 8'h17);
        step(1'b0, 1'b1, 8'h12, 8'h16);
        step(1'b0, 1'b0, 8'h12, 8'h16);

        // Saturation at zero.
        step(1'b1, 1'b0, 8'h02, 8'h02);
        step(1'b0, 1'b1, 8'h02, 8'h01);
        step(1'b0, 1'b1, 8'h02, 8'h00);
        step(1'b0, 1'b1, 8'h02, 8'h00);
        step(1'b0, 1'b1, 8'h02, 8'h00);

        // Load beats decrement.
        step(1'b1, 1'b1, 8'h50, 8'h50);
        step(1'b0, 1'b1, 8'h50, 8'h49);

        // Clamp and multi-digit ripple.
        step(1'b1, 1'b0, 8'hAF, 8'h99);
        step(1'b1, 1'b0, 8'h3F, 8'h39);
        step(1'b1, 1'b0, 8'h10, 8'h10);
        step(1'b0, 1'b1, 8'h10, 8'h09);
        step(1'b1, 1'b0, 8'h00, 8'h00);
        step(1'b1, 1'b0, 8'h01, 8'h01);
        step(1'b0, 1'b1, 8'h01, 8'h00);

        // Async reset in the middle of a countdown.
        step(1'b1, 1'b0, 8'h30, 8'h30);
        step(1'b0, 1'b1, 8'h30, 8'h29);
        step(1'b0, 1'b1, 8'h30, 8'h28);
        #3;
        reset = 1'b1;
        #1;
        direct_check("async_reset", 8'h00, 1'b1);
        #1;
        reset = 1'b0;
        step(1'b0, 1'b1, 8'h30, 8'h00);
        step(1'b0, 1'b1, 8'h30, 8'h00);
        step(1'b1, 1'b0, 8'h45, 8'h45);
        step(1'b0, 1'b1, 8'h45, 8'h44);

        @(negedge clk);
        writeEnable     = 1'b0;
        decrementEnable = 1'b0;
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
